// File: rtl/seq_divider4_if.sv
// Start/busy/done handshake and operand/result bus for seq_divider4.
// The master drives the request side; the divider is the slave.
interface seq_divider4_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero,
    input  overflow
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero,
    output overflow
  );
endinterface

// File: rtl/seq_divider4.sv
// Multi-cycle restoring divider: one trial subtraction per RUN cycle, WIDTH iterations.
// Define SIGNED_DIV_EN for two's-complement operands and a live overflow flag.
module seq_divider4 #(
  parameter int unsigned WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  seq_divider4_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
    $error("seq_divider4: WIDTH must be in 2..16");
  end

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH:0]    r_q, r_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              dbz_q, dbz_d;

  logic              accept;
  logic              last_iter;
  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    trial;
  logic [WIDTH:0]    r_next;
  logic [WIDTH-1:0]  q_next;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  q_fin;
  logic [WIDTH-1:0]  r_fin;

  assign accept    = (state_q == StIdle) && bus.start;
  assign last_iter = (state_q == StRun) && (cnt_q == CntW'(WIDTH - 1));

  // One restoring step: shift {R,Q} left, subtract divisor at WIDTH+1 bits, keep if no borrow.
  always_comb begin
    shifted = (r_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    r_next  = trial[WIDTH] ? shifted : trial;
    q_next  = {q_q[WIDTH-2:0], ~trial[WIDTH]};
  end

`ifdef SIGNED_DIV_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic ovfp_q, ovfp_d;
  logic ovf_q, ovf_d;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  // Magnitudes in at capture, signs back out at the final load.
  always_comb begin
    op_a  = bus.dividend[WIDTH-1] ? neg(bus.dividend) : bus.dividend;
    op_b  = bus.divisor[WIDTH-1] ? neg(bus.divisor) : bus.divisor;
    q_fin = qneg_q ? neg(q_next) : q_next;
    r_fin = rneg_q ? neg(r_next[WIDTH-1:0]) : r_next[WIDTH-1:0];
  end

  // Most-negative / -1 yields a magnitude quotient that already reads back as
  // most-negative, so only the flag needs special handling.
  always_comb begin
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    ovfp_d = ovfp_q;
    ovf_d  = ovf_q;
    if (accept) begin
      ovf_d  = 1'b0;
      qneg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      rneg_d = bus.dividend[WIDTH-1];
      ovfp_d = (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.divisor == '1);
    end
    if (last_iter) begin
      ovf_d = ovfp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      ovfp_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      ovfp_q <= ovfp_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.overflow = ovf_q;
`else
  assign op_a         = bus.dividend;
  assign op_b         = bus.divisor;
  assign q_fin        = q_next;
  assign r_fin        = r_next[WIDTH-1:0];
  assign bus.overflow = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          dbz_d = 1'b0;
          if (bus.divisor == '0) begin
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = StFin;
          end else begin
            r_d     = '0;
            q_d     = op_a;
            dvs_d   = op_b;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          quot_d  = q_fin;
          rem_d   = r_fin;
          cnt_d   = '0;
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    bus.busy        = (state_q == StRun);
    bus.done        = (state_q == StFin);
    bus.quotient    = quot_q;
    bus.remainder   = rem_q;
    bus.div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_divider4.sv
// Bench for seq_divider4: arithmetic reference model checked every cycle,
// plus directed literal cases, an exhaustive sweep and random traffic.
module tb_seq_divider4;
  localparam int W = 4;

  logic clk;
  logic rst;

  seq_divider4_if #(.WIDTH(W)) bus ();

  seq_divider4 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic straight from the operand rules.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic ov);
`ifdef SIGNED_DIV_EN
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (sa == -(1 << (W - 1)) && sb == -1) begin
      q  = a;
      r  = '0;
      ov = 1'b1;
    end else begin
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      ov = 1'b0;
    end
`else
    q  = a / b;
    r  = a % b;
    ov = 1'b0;
`endif
  endfunction

  // Model state: expected outputs after each rising edge.
  bit           model_on = 0;
  int           busy_left = 0;
  logic         e_busy = 0, e_done = 0, e_dbz = 0, e_ovf = 0;
  logic [W-1:0] e_q = '0, e_r = '0;
  logic [W-1:0] p_q, p_r;
  logic         p_ovf;

  task automatic model_step();
    logic fin_prev;
    if (rst) begin
      busy_left = 0;
      e_busy = 0; e_done = 0; e_q = '0; e_r = '0; e_dbz = 0; e_ovf = 0;
      model_on = 1;
    end else begin
      fin_prev = e_done;
      e_done   = 0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          e_busy = 0; e_done = 1; e_q = p_q; e_r = p_r; e_ovf = p_ovf;
        end
      end else if (!fin_prev && bus.start) begin
        e_dbz = 0;
        e_ovf = 0;
        if (bus.divisor == '0) begin
          e_done = 1; e_q = '1; e_r = bus.dividend; e_dbz = 1;
        end else begin
          ref_div(bus.dividend, bus.divisor, p_q, p_r, p_ovf);
          busy_left = W;
          e_busy    = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("busy", bus.busy, e_busy);
      chk("done", bus.done, e_done);
      chk("quotient", bus.quotient, e_q);
      chk("remainder", bus.remainder, e_r);
      chk("div_by_zero", bus.div_by_zero, e_dbz);
      chk("overflow", bus.overflow, e_ovf);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one request from idle and wait (bounded) for done; latency counted in
  // cycles after the capturing edge.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic ov);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    step();
    bus.start = 1'b0;
    lat = 0;
    for (int n = 1; n <= W + 4; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("done_timeout", 0, 1);
    q  = bus.quotient;
    r  = bus.remainder;
    dz = bus.div_by_zero;
    ov = bus.overflow;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           lat;
    int           n_done;
    logic [W-1:0] q, r;
    logic         dz, ov;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_busy", bus.busy, 0);
    chk("reset_quotient", bus.quotient, 0);

`ifndef SIGNED_DIV_EN
    run_div(4'd13, 4'd3, lat, q, r, dz, ov);
    chk("13/3_lat", lat, W + 1);
    chk("13/3_q", q, 4);
    chk("13/3_r", r, 1);
    chk("13/3_dbz", dz, 0);
    run_div(4'd15, 4'd1, lat, q, r, dz, ov);
    chk("15/1_q", q, 15);
    chk("15/1_r", r, 0);
    run_div(4'd3, 4'd7, lat, q, r, dz, ov);
    chk("3/7_q", q, 0);
    chk("3/7_r", r, 3);
    run_div(4'd15, 4'd15, lat, q, r, dz, ov);
    chk("15/15_q", q, 1);
    chk("15/15_r", r, 0);
`else
    run_div(4'b1001, 4'd2, lat, q, r, dz, ov);
    chk("-7/2_q", q, 4'b1101);
    chk("-7/2_r", r, 4'b1111);
    run_div(4'd7, 4'b1110, lat, q, r, dz, ov);
    chk("7/-2_q", q, 4'b1101);
    chk("7/-2_r", r, 4'b0001);
    run_div(4'b1000, 4'b1111, lat, q, r, dz, ov);
    chk("-8/-1_q", q, 4'b1000);
    chk("-8/-1_r", r, 0);
    chk("-8/-1_ovf", ov, 1);
    chk("-8/-1_lat", lat, W + 1);
`endif

    run_div(4'd5, 4'd0, lat, q, r, dz, ov);
    chk("5/0_lat", lat, 1);
    chk("5/0_q", q, 4'b1111);
    chk("5/0_r", r, 5);
    chk("5/0_dbz", dz, 1);

    // start re-asserted while running must be dropped, not queued.
    bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
    step();
    bus.dividend = 4'd9; bus.divisor = 4'd2;
    step();
    step();
    bus.start = 1'b0;
    n_done = 0;
    for (int n = 0; n < 3 * W; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    chk("ignored_start_done_count", n_done, 1);
`ifndef SIGNED_DIV_EN
    chk("hold_q", bus.quotient, 4);
    chk("hold_r", bus.remainder, 1);
`endif
    step();

    // Reset two cycles into RUN aborts with no done.
    bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
    step();
    bus.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_done = 0;
    for (int n = 0; n < W + 3; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    chk("abort_done_count", n_done, 0);
    chk("abort_quotient", bus.quotient, 0);
    step();
    run_div(4'd14, 4'd4, lat, q, r, dz, ov);
`ifndef SIGNED_DIV_EN
    chk("14/4_q", q, 3);
    chk("14/4_r", r, 2);
`endif

    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        run_div(W'(a), W'(b), lat, q, r, dz, ov);
        chk("sweep_lat", lat, (b == 0) ? 1 : W + 1);
`ifndef SIGNED_DIV_EN
        if (b != 0) chk("sweep_invariant", q * b + r, a);
`endif
      end
    end

    for (int i = 0; i < 1500; i++) begin
      rst          = ($urandom_range(0, 79) == 0);
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.dividend = W'($urandom_range(0, (1 << W) - 1));
      bus.divisor  = W'($urandom_range(0, (1 << W) - 1));
      step();
    end
    rst = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < W + 4; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
